// File: rtl/sipo_rx.sv
// ============================================================================
// Module   : sipo_rx
// Brief    : MSB-first serial-to-parallel receiver with ready/valid output,
//            sticky overrun flag and optional even parity (SIPO_RX_PARITY_EN).
// Revision : 1.0
// ============================================================================
`default_nettype none

module sipo_rx #(
   parameter int WIDTH = 4
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             serial_in,
   input  logic             serial_valid,
   input  logic             sync,
   output logic [WIDTH-1:0] parallel_out,
   output logic             out_valid,
   input  logic             out_ready,
   output logic             busy,
   output logic             overrun,
   output logic             parity_err
);

   localparam int             c_CNT_W   = $clog2(WIDTH + 1);
   localparam logic [c_CNT_W-1:0] c_LAST = c_CNT_W'(WIDTH - 1);
`ifdef SIPO_RX_PARITY_EN
   localparam int             c_SHIFT_W = WIDTH;
`else
   // The final data bit goes straight into the word, so one fewer bit is held.
   localparam int             c_SHIFT_W = WIDTH - 1;
`endif

   typedef enum logic [1:0] {
      S_IDLE  = 2'd0,
      S_SHIFT = 2'd1
`ifdef SIPO_RX_PARITY_EN
      ,
      S_PAR   = 2'd2
`endif
   } state_t;

   state_t               r_state;
   logic [c_CNT_W-1:0]   r_cnt;
   logic [c_SHIFT_W-1:0] r_shift;
   logic [WIDTH-1:0]     r_word;
   logic                 r_valid;
   logic                 r_busy;
   logic                 r_overrun;

   logic                 w_last;
   logic                 w_complete;
   logic [WIDTH-1:0]     w_word;
`ifdef SIPO_RX_PARITY_EN
   logic                 r_perr;
   logic                 w_perr;
`endif

   always_comb begin
      w_last = (r_cnt == c_LAST);
`ifdef SIPO_RX_PARITY_EN
      w_complete = serial_valid && !sync && (r_state == S_PAR);
      w_word     = r_shift;
      w_perr     = ^{r_shift, serial_in};
`else
      w_complete = serial_valid && !sync && w_last;
      w_word     = {r_shift, serial_in};
`endif
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         r_state   <= S_IDLE;
         r_cnt     <= '0;
         r_shift   <= '0;
         r_word    <= '0;
         r_valid   <= 1'b0;
         r_busy    <= 1'b0;
         r_overrun <= 1'b0;
`ifdef SIPO_RX_PARITY_EN
         r_perr    <= 1'b0;
`endif
      end else begin
         // A bit sampled together with sync becomes bit 1 of the new frame.
         if (sync) begin
            if (serial_valid) begin
               r_state <= S_SHIFT;
               r_cnt   <= c_CNT_W'(1);
               r_shift <= c_SHIFT_W'(serial_in);
               r_busy  <= 1'b1;
            end else begin
               r_state <= S_IDLE;
               r_cnt   <= '0;
               r_shift <= '0;
               r_busy  <= 1'b0;
            end
         end else if (serial_valid) begin
            case (r_state)
               S_IDLE, S_SHIFT: begin
`ifdef SIPO_RX_PARITY_EN
                  r_shift <= {r_shift[WIDTH-2:0], serial_in};
`else
                  r_shift <= w_word[c_SHIFT_W-1:0];
`endif
                  if (w_last) begin
`ifdef SIPO_RX_PARITY_EN
                     r_state <= S_PAR;
                     r_cnt   <= r_cnt + 1'b1;
                     r_busy  <= 1'b1;
`else
                     r_state <= S_IDLE;
                     r_cnt   <= '0;
                     r_busy  <= 1'b0;
`endif
                  end else begin
                     r_state <= S_SHIFT;
                     r_cnt   <= r_cnt + 1'b1;
                     r_busy  <= 1'b1;
                  end
               end
               default: begin
                  r_state <= S_IDLE;
                  r_cnt   <= '0;
                  r_busy  <= 1'b0;
               end
            endcase
         end

         if (w_complete) begin
            if (!r_valid || out_ready) begin
               r_word  <= w_word;
               r_valid <= 1'b1;
`ifdef SIPO_RX_PARITY_EN
               r_perr  <= w_perr;
`endif
            end else begin
               r_overrun <= 1'b1;
            end
         end else if (r_valid && out_ready) begin
            r_valid <= 1'b0;
         end
      end
   end

   assign parallel_out = r_word;
   assign out_valid    = r_valid;
   assign busy         = r_busy;
   assign overrun      = r_overrun;
`ifdef SIPO_RX_PARITY_EN
   assign parity_err   = r_perr;
`else
   assign parity_err   = 1'b0;
`endif

endmodule

`default_nettype wire

// File: tb/tb_sipo_rx.sv
// ============================================================================
// Module   : tb_sipo_rx
// Brief    : Directed, table-driven self-checking bench for sipo_rx (WIDTH=4).
// Revision : 1.0
// ============================================================================
`default_nettype none

module tb_sipo_rx;

   logic       clk = 1'b0;
   logic       rst;
   logic       serial_in;
   logic       serial_valid;
   logic       sync;
   logic [3:0] parallel_out;
   logic       out_valid;
   logic       out_ready;
   logic       busy;
   logic       overrun;
   logic       parity_err;

   int n_checks = 0;
   int n_pass   = 0;

   always #5 clk = ~clk;

   sipo_rx #(.WIDTH(4)) dut (
      .clk          (clk),
      .rst          (rst),
      .serial_in    (serial_in),
      .serial_valid (serial_valid),
      .sync         (sync),
      .parallel_out (parallel_out),
      .out_valid    (out_valid),
      .out_ready    (out_ready),
      .busy         (busy),
      .overrun      (overrun),
      .parity_err   (parity_err)
   );

   typedef struct {
      logic [3:0] bits;
      int         gap;
      logic [3:0] exp_word;
   } vec_t;

   vec_t vecs[5];

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got %0h expected %0h", name, act, exp);
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic send_bit(input logic b);
      serial_valid = 1'b1;
      serial_in    = b;
      tick();
      serial_valid = 1'b0;
      serial_in    = 1'b0;
   endtask

   // Sends one frame (plus even parity bit in the parity build).
   task automatic send_frame(input logic [3:0] w, input int gap, input bit ready_last,
                             input bit bad_par);
      logic [4:0] seq;
      int         nb;
`ifdef SIPO_RX_PARITY_EN
      seq = {w, (^w) ^ bad_par};
      nb  = 5;
`else
      seq = {1'b0, w};
      nb  = 4;
      if (bad_par) seq[4] = 1'b0;
`endif
      for (int i = nb - 1; i >= 0; i--) begin
         if (i == 0 && ready_last) out_ready = 1'b1;
         send_bit(seq[i]);
         if (i > 0) begin
            for (int g = 0; g < gap; g++) begin
               tick();
               check("busy_gap", 32'(busy), 32'd1);
            end
         end
      end
   endtask

   initial begin
      vecs[0] = '{bits: 4'b1011, gap: 0, exp_word: 4'b1011};
      vecs[1] = '{bits: 4'b0110, gap: 2, exp_word: 4'b0110};
      vecs[2] = '{bits: 4'b0000, gap: 0, exp_word: 4'b0000};
      vecs[3] = '{bits: 4'b1111, gap: 1, exp_word: 4'b1111};
      vecs[4] = '{bits: 4'b1000, gap: 3, exp_word: 4'b1000};

      rst = 1'b1; serial_in = 1'b0; serial_valid = 1'b0; sync = 1'b0; out_ready = 1'b0;
      tick(); tick();
      check("rst_out",     32'(parallel_out), 32'h0);
      check("rst_valid",   32'(out_valid),    32'd0);
      check("rst_busy",    32'(busy),         32'd0);
      check("rst_overrun", 32'(overrun),      32'd0);
      check("rst_perr",    32'(parity_err),   32'd0);
      rst = 1'b0;

      // Table: capture with out_ready held high.
      out_ready = 1'b1;
      for (int i = 0; i < 5; i++) begin
         send_frame(vecs[i].bits, vecs[i].gap, 1'b0, 1'b0);
         check("tbl_valid",   32'(out_valid),    32'd1);
         check("tbl_word",    32'(parallel_out), 32'(vecs[i].exp_word));
         check("tbl_busy",    32'(busy),         32'd0);
         check("tbl_perr",    32'(parity_err),   32'd0);
         check("tbl_overrun", 32'(overrun),      32'd0);
         tick();
         check("tbl_drain",   32'(out_valid),    32'd0);
      end

      // Completion coinciding with handshake keeps valid high, no overrun.
      out_ready = 1'b0;
      send_frame(4'b1100, 0, 1'b0, 1'b0);
      check("coin_first", 32'(parallel_out), 32'hC);
      send_frame(4'b0101, 0, 1'b1, 1'b0);
      check("coin_word",    32'(parallel_out), 32'h5);
      check("coin_valid",   32'(out_valid),    32'd1);
      check("coin_overrun", 32'(overrun),      32'd0);
      tick();
      check("coin_drain",   32'(out_valid),    32'd0);

      // Backpressure: second word dropped, overrun sticky.
      out_ready = 1'b0;
      send_frame(4'b1001, 0, 1'b0, 1'b0);
      check("bp_first",   32'(parallel_out), 32'h9);
      send_frame(4'b0011, 0, 1'b0, 1'b0);
      check("bp_hold",    32'(parallel_out), 32'h9);
      check("bp_valid",   32'(out_valid),    32'd1);
      check("bp_overrun", 32'(overrun),      32'd1);
      out_ready = 1'b1;
      tick();
      out_ready = 1'b0;
      check("bp_drain",   32'(out_valid),    32'd0);
      check("bp_sticky",  32'(overrun),      32'd1);

      // Reset mid-frame with a pending word.
      send_frame(4'b1110, 0, 1'b0, 1'b0);
      send_bit(1'b1);
      send_bit(1'b0);
      check("mid_busy", 32'(busy), 32'd1);
      rst = 1'b1;
      tick(); tick();
      rst = 1'b0;
      check("mrst_out",     32'(parallel_out), 32'h0);
      check("mrst_valid",   32'(out_valid),    32'd0);
      check("mrst_busy",    32'(busy),         32'd0);
      check("mrst_overrun", 32'(overrun),      32'd0);
      out_ready = 1'b1;
      send_frame(4'b0111, 0, 1'b0, 1'b0);
      check("mrst_fresh", 32'(parallel_out), 32'h7);
      tick();

      // Sync together with a valid bit restarts the frame at bit 1.
      send_bit(1'b1);
      send_bit(1'b1);
      sync = 1'b1;
      send_bit(1'b0);
      sync = 1'b0;
      check("sync_busy", 32'(busy), 32'd1);
      send_bit(1'b1);
      send_bit(1'b0);
      send_bit(1'b1);
`ifdef SIPO_RX_PARITY_EN
      send_bit(1'b0);
`endif
      check("sync_word",    32'(parallel_out), 32'h5);
      check("sync_valid",   32'(out_valid),    32'd1);
      check("sync_overrun", 32'(overrun),      32'd0);
      tick();

      // Sync alone returns to idle.
      send_bit(1'b1);
      sync = 1'b1;
      tick();
      sync = 1'b0;
      check("sync_idle", 32'(busy), 32'd0);
      send_frame(4'b1010, 0, 1'b0, 1'b0);
      check("sync_after", 32'(parallel_out), 32'hA);
      tick();

`ifdef SIPO_RX_PARITY_EN
      send_frame(4'b1011, 0, 1'b0, 1'b0);
      check("par_good_word", 32'(parallel_out), 32'hB);
      check("par_good",      32'(parity_err),   32'd0);
      tick();
      send_frame(4'b1011, 0, 1'b0, 1'b1);
      check("par_bad", 32'(parity_err), 32'd1);
      tick();
`endif

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule

`default_nettype wire
